// File: rtl/axi_wr_arbiter.sv
// Two-requester AXI write-channel arbiter: one AW/W/B transaction owned at a time, round-robin on ties.
// Optional WR_ARB_FIXED_PRIO_EN: requester 0 wins every tie.
module axi_wr_arbiter #(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [AW-1:0]   m0_awaddr,
  input  logic [7:0]      m0_awlen,
  input  logic [2:0]      m0_awsize,
  input  logic [1:0]      m0_awburst,
  input  logic            m0_awvalid,
  output logic            m0_awready,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_wstrb,
  input  logic            m0_wvalid,
  output logic            m0_wready,
  output logic [1:0]      m0_bresp,
  output logic            m0_bvalid,
  input  logic            m0_bready,
  input  logic [AW-1:0]   m1_awaddr,
  input  logic [7:0]      m1_awlen,
  input  logic [2:0]      m1_awsize,
  input  logic [1:0]      m1_awburst,
  input  logic            m1_awvalid,
  output logic            m1_awready,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wstrb,
  input  logic            m1_wvalid,
  output logic            m1_wready,
  output logic [1:0]      m1_bresp,
  output logic            m1_bvalid,
  input  logic            m1_bready,
  output logic [AW-1:0]   axi_awaddr,
  output logic [7:0]      axi_awlen,
  output logic [2:0]      axi_awsize,
  output logic [1:0]      axi_awburst,
  output logic            axi_awvalid,
  input  logic            axi_awready,
  output logic [DW-1:0]   axi_wdata,
  output logic [DW/8-1:0] axi_wstrb,
  output logic            axi_wlast,
  output logic            axi_wvalid,
  input  logic            axi_wready,
  input  logic [1:0]      axi_bresp,
  input  logic            axi_bvalid,
  output logic            axi_bready,
  output logic            grant,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t          state_q, state_d;
  logic            grant_q, grant_d;
  logic            last_q, last_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [AW-1:0]   awaddr_q, awaddr_d;
  logic [7:0]      awlen_q, awlen_d;
  logic [2:0]      awsize_q, awsize_d;
  logic [1:0]      awburst_q, awburst_d;

  logic            win, accept, w_hs, b_hs;
  logic            own_wvalid, own_bready;

  always_comb begin
    win = m1_awvalid;
    if (m0_awvalid && m1_awvalid) begin
`ifdef WR_ARB_FIXED_PRIO_EN
      win = 1'b0;
`else
      win = ~last_q;
`endif
    end
  end

  assign own_wvalid = grant_q ? m1_wvalid : m0_wvalid;
  assign own_bready = grant_q ? m1_bready : m0_bready;
  assign accept     = (state_q == IDLE) && (m0_awvalid || m1_awvalid);
  assign w_hs       = (state_q == DATA) && own_wvalid && axi_wready;
  assign b_hs       = (state_q == RESP) && axi_bvalid && own_bready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = ADDR;
      ADDR: if (axi_awready) state_d = DATA;
      DATA: if (w_hs && cnt_q == 8'd0) state_d = RESP;
      RESP: if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Owner-side ready/valid are pure muxes so the W and B paths add no latency.
  always_comb begin
    m0_awready  = resetn && accept && !win;
    m1_awready  = resetn && accept && win;
    axi_awvalid = (state_q == ADDR);
    axi_awaddr  = awaddr_q;
    axi_awlen   = awlen_q;
    axi_awsize  = awsize_q;
    axi_awburst = awburst_q;
    axi_wvalid  = (state_q == DATA) && own_wvalid;
    axi_wdata   = '0;
    axi_wstrb   = '0;
    axi_wlast   = (state_q == DATA) && (cnt_q == 8'd0);
    m0_wready   = (state_q == DATA) && !grant_q && axi_wready;
    m1_wready   = (state_q == DATA) && grant_q && axi_wready;
    if (state_q == DATA) begin
      axi_wdata = grant_q ? m1_wdata : m0_wdata;
      axi_wstrb = grant_q ? m1_wstrb : m0_wstrb;
    end
    axi_bready  = (state_q == RESP) && own_bready;
    m0_bvalid   = (state_q == RESP) && !grant_q && axi_bvalid;
    m1_bvalid   = (state_q == RESP) && grant_q && axi_bvalid;
    m0_bresp    = ((state_q == RESP) && !grant_q) ? axi_bresp : 2'b00;
    m1_bresp    = ((state_q == RESP) && grant_q) ? axi_bresp : 2'b00;
    grant       = grant_q;
    busy        = (state_q != IDLE);
  end

  always_comb begin
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    awsize_d  = awsize_q;
    awburst_d = awburst_q;
    if (accept) begin
      grant_d   = win;
      awaddr_d  = win ? m1_awaddr  : m0_awaddr;
      awlen_d   = win ? m1_awlen   : m0_awlen;
      awsize_d  = win ? m1_awsize  : m0_awsize;
      awburst_d = win ? m1_awburst : m0_awburst;
      cnt_d     = win ? m1_awlen   : m0_awlen;
    end
    // The final beat leaves the counter at zero instead of wrapping.
    if (w_hs && cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
    if (b_hs) last_d = grant_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= 8'd0;
      awaddr_q  <= '0;
      awlen_q   <= 8'd0;
      awsize_q  <= 3'd0;
      awburst_q <= 2'd0;
    end else begin
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      awsize_q  <= awsize_d;
      awburst_q <= awburst_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter: drives both requesters and the shared slave side by hand.
module tb_axi_wr_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
`ifdef WR_ARB_FIXED_PRIO_EN
  localparam bit TIE_WIN = 1'b0;
`else
  localparam bit TIE_WIN = 1'b1;
`endif

  logic clk = 1'b0;
  logic resetn;
  logic [AW-1:0] m_awaddr [2];
  logic [7:0]    m_awlen [2];
  logic [2:0]    m_awsize [2];
  logic [1:0]    m_awburst [2];
  logic [DW-1:0] m_wdata [2];
  logic [7:0]    m_wstrb [2];
  logic [1:0]    m_awvalid, m_wvalid, m_bready;
  wire  [1:0]    m_awready, m_wready, m_bvalid;
  wire  [1:0]    m_bresp [2];
  wire  [AW-1:0] axi_awaddr;
  wire  [7:0]    axi_awlen;
  wire  [2:0]    axi_awsize;
  wire  [1:0]    axi_awburst;
  wire           axi_awvalid, axi_wlast, axi_wvalid, axi_bready, grant, busy;
  wire  [DW-1:0] axi_wdata;
  wire  [7:0]    axi_wstrb;
  logic          axi_awready, axi_wready, axi_bvalid;
  logic [1:0]    axi_bresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_wr_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .resetn(resetn),
    .m0_awaddr(m_awaddr[0]), .m0_awlen(m_awlen[0]), .m0_awsize(m_awsize[0]), .m0_awburst(m_awburst[0]),
    .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]),
    .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]), .m0_bresp(m_bresp[0]), .m0_bvalid(m_bvalid[0]),
    .m0_bready(m_bready[0]),
    .m1_awaddr(m_awaddr[1]), .m1_awlen(m_awlen[1]), .m1_awsize(m_awsize[1]), .m1_awburst(m_awburst[1]),
    .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]),
    .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]), .m1_bresp(m_bresp[1]), .m1_bvalid(m_bvalid[1]),
    .m1_bready(m_bready[1]),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .grant(grant), .busy(busy)
  );

  function automatic logic [DW-1:0] pat(input logic [31:0] a, input int b);
    return {a, 32'(b) ^ 32'h5A5A_0000};
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input bit who, input logic [31:0] addr, input logic [7:0] len);
    m_awaddr[who]  = addr;
    m_awlen[who]   = len;
    m_awsize[who]  = 3'd3;
    m_awburst[who] = 2'd1;
    m_awvalid[who] = 1'b1;
  endtask

  // Full transaction for requester `who`; entered and left just after a falling edge.
  task automatic do_txn(input bit who, input logic [31:0] addr, input logic [7:0] len,
                        input int aw_wait, input int b_wait, input bit other_req, input logic [1:0] resp);
    bit oth;
    oth = ~who;
    set_req(who, addr, len);
    m_wvalid[who] = 1'b1;
    m_wdata[who]  = pat(addr, 0);
    m_wstrb[who]  = 8'hF0;
    #1;
    checks++; if (m_awready[who] !== 1'b1) begin errors++; $display("FAIL winner_awready m%0d got=%b exp=1", who, m_awready[who]); end
    checks++; if (m_awready[oth] !== 1'b0) begin errors++; $display("FAIL loser_awready m%0d got=%b exp=0", oth, m_awready[oth]); end
    checks++; if (axi_wvalid !== 1'b0 || m_wready[who] !== 1'b0) begin errors++; $display("FAIL idle_w_held wvalid=%b wready=%b exp=0,0", axi_wvalid, m_wready[who]); end
    next_cyc();
    m_awvalid[who] = 1'b0;
    if (other_req) begin
      set_req(oth, addr + 32'h100, 8'd1);
      m_wvalid[oth] = 1'b1;
      m_wdata[oth]  = 64'hBAD0_BAD0_BAD0_BAD0;
      m_wstrb[oth]  = 8'h0F;
    end
    for (int k = 0; k < aw_wait; k++) begin
      #1;
      checks++; if (axi_awvalid !== 1'b1 || axi_awaddr !== addr || axi_awlen !== len || axi_awsize !== 3'd3 || axi_awburst !== 2'd1)
        begin errors++; $display("FAIL aw_hold cyc%0d valid=%b addr=%h len=%0d exp=1,%h,%0d", k, axi_awvalid, axi_awaddr, axi_awlen, addr, len); end
      checks++; if (grant !== who || busy !== 1'b1) begin errors++; $display("FAIL aw_grant grant=%b busy=%b exp=%b,1", grant, busy, who); end
      checks++; if (axi_wvalid !== 1'b0 || m_wready[who] !== 1'b0) begin errors++; $display("FAIL aw_w_held wvalid=%b wready=%b exp=0,0", axi_wvalid, m_wready[who]); end
      checks++; if (m_awready[oth] !== 1'b0) begin errors++; $display("FAIL aw_no_regrant got=%b exp=0", m_awready[oth]); end
      next_cyc();
    end
    axi_awready = 1'b1;
    #1;
    checks++; if (axi_awvalid !== 1'b1 || axi_awaddr !== addr || grant !== who) begin errors++; $display("FAIL aw_accept valid=%b addr=%h grant=%b exp=1,%h,%b", axi_awvalid, axi_awaddr, grant, addr, who); end
    next_cyc();
    axi_awready = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      m_wdata[who] = pat(addr, b);
      m_wstrb[who] = 8'hF0 ^ 8'(b);
      axi_wready = 1'b1;
      #1;
      checks++; if (axi_awvalid !== 1'b0) begin errors++; $display("FAIL data_awvalid beat%0d got=%b exp=0", b, axi_awvalid); end
      checks++; if (axi_wvalid !== 1'b1 || m_wready[who] !== 1'b1) begin errors++; $display("FAIL beat_hs beat%0d wvalid=%b wready=%b exp=1,1", b, axi_wvalid, m_wready[who]); end
      checks++; if (m_wready[oth] !== 1'b0) begin errors++; $display("FAIL nonowner_wready beat%0d got=%b exp=0", b, m_wready[oth]); end
      checks++; if (axi_wdata !== pat(addr, b) || axi_wstrb !== (8'hF0 ^ 8'(b))) begin errors++; $display("FAIL beat_data beat%0d got=%h/%h exp=%h/%h", b, axi_wdata, axi_wstrb, pat(addr, b), 8'hF0 ^ 8'(b)); end
      checks++; if (axi_wlast !== (b == int'(len))) begin errors++; $display("FAIL wlast beat%0d got=%b exp=%b", b, axi_wlast, b == int'(len)); end
      checks++; if (m_awready[oth] !== 1'b0) begin errors++; $display("FAIL data_no_regrant got=%b exp=0", m_awready[oth]); end
      next_cyc();
    end
    axi_wready = 1'b0;
    m_wvalid[who] = 1'b0;
    axi_bvalid = 1'b1;
    axi_bresp = resp;
    for (int k = 0; k < b_wait; k++) begin
      #1;
      checks++; if (m_bvalid[who] !== 1'b1 || axi_bready !== 1'b0) begin errors++; $display("FAIL resp_wait bvalid=%b bready=%b exp=1,0", m_bvalid[who], axi_bready); end
      checks++; if (busy !== 1'b1 || m_awready[oth] !== 1'b0) begin errors++; $display("FAIL resp_no_regrant busy=%b awready=%b exp=1,0", busy, m_awready[oth]); end
      checks++; if (m_bvalid[oth] !== 1'b0 || axi_wvalid !== 1'b0) begin errors++; $display("FAIL resp_isolation bvalid=%b wvalid=%b exp=0,0", m_bvalid[oth], axi_wvalid); end
      next_cyc();
    end
    m_bready[who] = 1'b1;
    #1;
    checks++; if (axi_bready !== 1'b1 || m_bvalid[who] !== 1'b1) begin errors++; $display("FAIL resp_hs bready=%b bvalid=%b exp=1,1", axi_bready, m_bvalid[who]); end
    checks++; if (m_bresp[who] !== resp || m_bvalid[oth] !== 1'b0) begin errors++; $display("FAIL resp_route bresp=%b other_bvalid=%b exp=%b,0", m_bresp[who], m_bvalid[oth], resp); end
    next_cyc();
    axi_bvalid = 1'b0;
    m_bready[who] = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || axi_bready !== 1'b0) begin errors++; $display("FAIL back_idle busy=%b bready=%b exp=0,0", busy, axi_bready); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0 || grant !== 1'b0) begin errors++; $display("FAIL reset_state busy=%b grant=%b exp=0,0", busy, grant); end
    checks++; if (axi_awvalid !== 1'b0 || axi_wvalid !== 1'b0 || axi_wlast !== 1'b0 || axi_bready !== 1'b0)
      begin errors++; $display("FAIL reset_valids aw=%b w=%b last=%b b=%b exp=0", axi_awvalid, axi_wvalid, axi_wlast, axi_bready); end
    checks++; if (axi_awaddr !== '0 || axi_awlen !== 8'd0 || m_bvalid !== 2'b00 || m_wready !== 2'b00 || m_awready !== 2'b00)
      begin errors++; $display("FAIL reset_fields addr=%h len=%0d bvalid=%b wready=%b awready=%b exp=0", axi_awaddr, axi_awlen, m_bvalid, m_wready, m_awready); end
    @(negedge clk);
    resetn = 1'b1;
    #1;
  endtask

  task automatic test_single_burst();
    do_txn(1'b0, 32'h0000_1000, 8'd3, 0, 0, 1'b0, 2'b00);
  endtask

  task automatic test_aw_stall();
    do_txn(1'b1, 32'h0000_2000, 8'd1, 5, 0, 1'b0, 2'b10);
  endtask

  task automatic test_round_robin();
    set_req(1'b1, 32'h0000_3100, 8'd0);
    do_txn(1'b0, 32'h0000_3000, 8'd0, 0, 0, 1'b0, 2'b00);
    do_txn(1'b1, 32'h0000_3100, 8'd0, 0, 0, 1'b0, 2'b01);
    set_req(1'b1, 32'h0000_4100, 8'd0);
    do_txn(1'b0, 32'h0000_4000, 8'd0, 0, 0, 1'b0, 2'b00);
    do_txn(1'b1, 32'h0000_4100, 8'd0, 0, 0, 1'b0, 2'b00);
  endtask

  task automatic test_tie_after_m0();
    do_txn(1'b0, 32'h0000_6000, 8'd0, 0, 0, 1'b0, 2'b00);
    set_req(1'b0, 32'h0000_6100, 8'd0);
    set_req(1'b1, 32'h0000_6200, 8'd0);
    do_txn(TIE_WIN, TIE_WIN ? 32'h0000_6200 : 32'h0000_6100, 8'd0, 0, 0, 1'b0, 2'b00);
    do_txn(!TIE_WIN, TIE_WIN ? 32'h0000_6100 : 32'h0000_6200, 8'd0, 0, 0, 1'b0, 2'b00);
  endtask

  task automatic test_back_to_back();
    do_txn(1'b0, 32'h0000_5000, 8'd3, 0, 3, 1'b1, 2'b11);
    do_txn(1'b1, 32'h0000_5100, 8'd1, 0, 0, 1'b0, 2'b00);
  endtask

  task automatic test_max_burst();
    do_txn(1'b0, 32'h0000_7000, 8'd255, 0, 0, 1'b0, 2'b00);
  endtask

  task automatic test_reset_mid();
    set_req(1'b1, 32'h0000_8000, 8'd7);
    m_wvalid[1] = 1'b1;
    m_wdata[1]  = pat(32'h0000_8000, 0);
    next_cyc();
    m_awvalid[1] = 1'b0;
    axi_awready = 1'b1;
    next_cyc();
    axi_awready = 1'b0;
    axi_wready = 1'b1;
    next_cyc();
    next_cyc();
    checks++; if (axi_wvalid !== 1'b1 || grant !== 1'b1 || axi_awaddr !== 32'h0000_8000)
      begin errors++; $display("FAIL mid_burst wvalid=%b grant=%b addr=%h exp=1,1,00008000", axi_wvalid, grant, axi_awaddr); end
    resetn = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || grant !== 1'b0 || axi_wvalid !== 1'b0 || axi_wlast !== 1'b0 || m_wready !== 2'b00)
      begin errors++; $display("FAIL async_reset busy=%b grant=%b wvalid=%b wlast=%b wready=%b exp=0", busy, grant, axi_wvalid, axi_wlast, m_wready); end
    checks++; if (axi_awvalid !== 1'b0 || axi_awaddr !== '0 || axi_awlen !== 8'd0 || axi_bready !== 1'b0)
      begin errors++; $display("FAIL async_reset_aw valid=%b addr=%h len=%0d bready=%b exp=0", axi_awvalid, axi_awaddr, axi_awlen, axi_bready); end
    axi_wready = 1'b0;
    m_wvalid[1] = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    do_txn(1'b1, 32'h0000_9000, 8'd2, 0, 0, 1'b0, 2'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_awaddr[i] = '0; m_awlen[i] = '0; m_awsize[i] = '0; m_awburst[i] = '0;
      m_wdata[i] = '0; m_wstrb[i] = '0;
    end
    m_awvalid = 2'b00; m_wvalid = 2'b00; m_bready = 2'b00;
    axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'b00;
    test_reset();
    test_single_burst();
    test_aw_stall();
    test_round_robin();
    test_tie_after_m0();
    test_back_to_back();
    test_max_burst();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
